wave_sequencer: RTL and testbench
=================================

// Module: wave_sequencer
// PURPOSE
//  Scheduler for the 4-voice PWM waveform mixer (sine/saw/tri/square summer).
//  Steps through a programmable table of {dwell, scale, voice-enable} entries.
//  Drives the mixer's Enable_SW/Scale inputs, changing them only on PWM-frame
//  boundaries. When idle, registered manual switch values pass through instead.
// PARAMETERS
//  STEPS      8    table depth (entries); index width = clog2(STEPS)
//  DWELL_W    16   dwell field width, unit = PWM frames
//  FRAME_LEN  64   sysclk cycles per PWM frame (matches the 6-bit mixer counter)
// PORTS
//  sysclk     in   1        system clock, all logic on posedge
//  rst_n      in   1        synchronous reset, active-low
//  man_enable in   4        manual voice enables (used in IDLE)
//  man_scale  in   6        manual scale (used in IDLE)
//  start      in   1        level; begin sequence (sampled in IDLE)
//  stop       in   1        level; abort sequence
//  loop       in   1        1 = wrap to step 0 at end of table, 0 = finish
//  wr_en      in   1        table write strobe
//  wr_addr    in   3        table entry index
//  wr_data    in   26       {dwell[15:0], scale[5:0], enable[3:0]}
//  Enable_SW  out  4        voice enables to mixer (registered)
//  Scale      out  6        scale to mixer (registered)
//  frame_tick out  1        high on last cycle of each frame (frame_cnt==FRAME_LEN-1)
//  busy       out  1        high in ARM or RUN
//  step_idx   out  3        index of the entry currently driving outputs
//  done       out  1        1-cycle pulse when a non-looping sequence ends
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - frame_cnt=0; state=IDLE; all table entries=0.
//   - Enable_SW=0, Scale=0, busy=0, done=0, step_idx=0.
//  Frame counter:
//   - frame_cnt runs 0..FRAME_LEN-1 and wraps.
//   - Any output update happens only on the posedge where frame_tick=1.
//   - New values are visible from frame_cnt=0 onward.
//  FSM states: IDLE, ARM, RUN.
//   IDLE
//    - At each frame_tick: Enable_SW<=man_enable, Scale<=man_scale.
//    - start=1 & stop=0 -> ARM.
//   ARM
//    - Waits for frame_tick, then loads entry 0: outputs<=entry, step_idx<=0,
//      dwell_cnt<=1 -> RUN.
//    - If entry 0 dwell==0: done pulse, go to IDLE; outputs take manual values
//      at that tick.
//   RUN, at each frame_tick:
//    - dwell_cnt<dwell: dwell_cnt+1.
//    - Otherwise advance: next = step_idx+1.
//    - If next==STEPS or entry[next].dwell==0 (terminator), end of table:
//      loop=1 -> load entry 0; loop=0 -> done=1 for 1 cycle, go to IDLE, load
//      manual values.
//    - Else load entry[next], dwell_cnt<=1.
//    - Net effect: each entry drives exactly dwell frames.
//  stop=1 in ARM/RUN:
//   - Go to IDLE at the next frame_tick with manual values; no done pulse.
//   - stop and start together: stop wins.
//  Table writes:
//   - Writes complete in 1 cycle and are allowed in any state.
//   - A write to the active entry does not change live outputs; it is used the
//     next time that entry loads.
//   - Same-cycle write and load of one entry: the load uses the old data.
//  Width rules: dwell_cnt is DWELL_W bits and never wraps (max dwell 65535).
//  Reset mid-sequence: immediate return to reset values; table is cleared.
//  busy = (state!=IDLE). Outputs never glitch mid-frame.
// TESTING
//  1. Reset, man_enable=4'b0101, man_scale=20 -> Enable_SW=5, Scale=20 from
//     the first frame_cnt=0 after a tick; not before.
//  2. Table {3,40,1},{2,10,8}, entry2 dwell=0, loop=0, pulse start ->
//     Enable_SW=1/Scale=40 for 192 cycles, then 8/10 for 128 cycles, then
//     done pulse, manual values.
//  3. Same table, loop=1 -> pattern repeats 1,1,1,8,8,1,... per frame;
//     done never asserts.
//  4. stop asserted mid-frame during step 1 -> outputs hold to frame end,
//     then manual values, busy=0, done=0.
//  5. Entry 0 dwell=0, start -> done at first tick, never RUN;
//     start+stop together -> stays IDLE.
//  6. All 8 entries dwell=1, loop=0 -> 8 frames, step_idx 0..7, done after
//     step 7; rst_n low mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/wave_sequencer.sv
// Table-driven scheduler for the 4-voice PWM mixer: steps through {dwell, scale, enable}
// entries and updates the mixer controls only on PWM-frame boundaries.
module wave_sequencer #(
  parameter int STEPS     = 8,
  parameter int DWELL_W   = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic [3:0]                 man_enable,
  input  logic [5:0]                 man_scale,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic                       wr_en,
  input  logic [$clog2(STEPS)-1:0]   wr_addr,
  input  logic [DWELL_W+9:0]         wr_data,
  output logic [3:0]                 Enable_SW,
  output logic [5:0]                 Scale,
  output logic                       frame_tick,
  output logic                       busy,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       done
);

  localparam int IDX_W = $clog2(STEPS);
  localparam int FC_W  = $clog2(FRAME_LEN);
  localparam int ENT_W = DWELL_W + 10;
  localparam logic [FC_W-1:0]  LAST_CNT  = FC_W'(FRAME_LEN - 1);
  localparam logic [IDX_W:0]   STEPS_EXT = (IDX_W + 1)'(STEPS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARM = 2'd1, ST_RUN = 2'd2} state_e;

  function automatic logic [DWELL_W-1:0] dwell_of(input logic [ENT_W-1:0] e);
    return e[ENT_W-1:10];
  endfunction

  state_e               state_q, state_d;
  logic [FC_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                 frame_tick_q, frame_tick_d;
  logic                 stop_req_q, stop_req_d;
  logic [3:0]           enable_q, enable_d;
  logic [5:0]           scale_q, scale_d;
  logic [IDX_W-1:0]     step_idx_q, step_idx_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]   cur_dwell_q, cur_dwell_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ENT_W-1:0]     table_q [STEPS];
  logic [ENT_W-1:0]     table_d [STEPS];

  logic                 load_s;
  logic [IDX_W-1:0]     load_idx_s;
  logic                 idle_s;
  logic                 stop_hit_s;
  logic [IDX_W:0]       next_s;
  logic [ENT_W-1:0]     load_ent_s;

  // Next-state logic: frame counter, sequencing FSM, table writes
  always_comb begin
    frame_cnt_d  = frame_tick_q ? '0 : frame_cnt_q + FC_W'(1);
    frame_tick_d = (frame_cnt_d == LAST_CNT);
    state_d      = state_q;
    stop_req_d   = stop_req_q;
    enable_d     = enable_q;
    scale_d      = scale_q;
    step_idx_d   = step_idx_q;
    dwell_cnt_d  = dwell_cnt_q;
    cur_dwell_d  = cur_dwell_q;
    done_d       = 1'b0;
    load_s       = 1'b0;
    load_idx_s   = '0;
    idle_s       = 1'b0;
    stop_hit_s   = stop_req_q | stop;
    next_s       = {1'b0, step_idx_q} + (IDX_W + 1)'(1);

    table_d = table_q;
    if (wr_en) begin
      table_d[wr_addr] = wr_data;
    end else begin
      table_d = table_q;
    end

    case (state_q)
      ST_IDLE: begin
        stop_req_d = 1'b0;
        if (start && !stop) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        stop_req_d = stop_hit_s;
        if (!frame_tick_q) begin
          load_s = 1'b0;
        end else if (stop_hit_s) begin
          idle_s = 1'b1;
        end else if (dwell_of(table_q[0]) == '0) begin
          idle_s = 1'b1;
          done_d = 1'b1;
        end else begin
          load_s = 1'b1;
        end
      end
      ST_RUN: begin
        stop_req_d = stop_hit_s;
        if (!frame_tick_q) begin
          load_s = 1'b0;
        end else if (stop_hit_s) begin
          idle_s = 1'b1;
        end else if (dwell_cnt_q < cur_dwell_q) begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end else if (next_s != STEPS_EXT && dwell_of(table_q[next_s[IDX_W-1:0]]) != '0) begin
          load_s     = 1'b1;
          load_idx_s = next_s[IDX_W-1:0];
        end else if (loop && dwell_of(table_q[0]) != '0) begin
          load_s = 1'b1;
        end else begin
          idle_s = 1'b1;
          done_d = 1'b1;
        end
      end
      default: begin
        idle_s = 1'b1;
      end
    endcase

    // Loads read the pre-write table, so a same-cycle write only affects later loads
    load_ent_s = table_q[load_idx_s];
    if (load_s) begin
      enable_d    = load_ent_s[3:0];
      scale_d     = load_ent_s[9:4];
      cur_dwell_d = dwell_of(load_ent_s);
      dwell_cnt_d = DWELL_W'(1);
      step_idx_d  = load_idx_s;
      state_d     = ST_RUN;
    end else if (idle_s) begin
      enable_d   = man_enable;
      scale_d    = man_scale;
      step_idx_d = '0;
      stop_req_d = 1'b0;
      state_d    = ST_IDLE;
    end else if (state_q == ST_IDLE && frame_tick_q) begin
      enable_d = man_enable;
      scale_d  = man_scale;
    end else begin
      enable_d = enable_q;
      scale_d  = scale_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
      stop_req_q   <= 1'b0;
      enable_q     <= '0;
      scale_q      <= '0;
      step_idx_q   <= '0;
      dwell_cnt_q  <= '0;
      cur_dwell_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= frame_tick_d;
      stop_req_q   <= stop_req_d;
      enable_q     <= enable_d;
      scale_q      <= scale_d;
      step_idx_q   <= step_idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      cur_dwell_q  <= cur_dwell_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      table_q      <= table_d;
    end
  end

  assign Enable_SW  = enable_q;
  assign Scale      = scale_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;
  assign step_idx   = step_idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a frame-level behavioural model.
module tb_wave_sequencer;

  logic        sysclk;
  logic        rst_n;
  logic [3:0]  man_enable;
  logic [5:0]  man_scale;
  logic        start;
  logic        stop;
  logic        loop;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [25:0] wr_data;
  logic [3:0]  Enable_SW;
  logic [5:0]  Scale;
  logic        frame_tick;
  logic        busy;
  logic [2:0]  step_idx;
  logic        done;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0=idle, 1=armed, 2=running
  int          m_cnt;
  int          m_mode;
  logic [3:0]  m_en;
  logic [5:0]  m_sc;
  int          m_idx;
  int          m_left;
  bit          m_stop;
  bit          m_done;
  logic [25:0] m_tab [8];

  wave_sequencer dut (
    .sysclk(sysclk), .rst_n(rst_n), .man_enable(man_enable), .man_scale(man_scale),
    .start(start), .stop(stop), .loop(loop), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .Enable_SW(Enable_SW), .Scale(Scale), .frame_tick(frame_tick),
    .busy(busy), .step_idx(step_idx), .done(done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int dw(input logic [25:0] e);
    return int'(e[25:10]);
  endfunction

  task automatic model_load(input int i);
    m_en   = m_tab[i][3:0];
    m_sc   = m_tab[i][9:4];
    m_left = dw(m_tab[i]) - 1;
    m_idx  = i;
    m_mode = 2;
  endtask

  task automatic model_step();
    bit tick;
    bit to_idle;
    int nxt;
    if (!rst_n) begin
      m_cnt = 0; m_mode = 0; m_en = 4'd0; m_sc = 6'd0; m_idx = 0;
      m_left = 0; m_stop = 1'b0; m_done = 1'b0;
      for (int i = 0; i < 8; i++) m_tab[i] = 26'd0;
      return;
    end
    tick    = (m_cnt == 63);
    m_done  = 1'b0;
    to_idle = 1'b0;
    if (m_mode == 0) begin
      m_stop = 1'b0;
      if (tick) begin
        m_en = man_enable;
        m_sc = man_scale;
      end
      if (start && !stop) m_mode = 1;
    end else begin
      if (stop) m_stop = 1'b1;
      if (tick) begin
        if (m_stop) begin
          to_idle = 1'b1;
        end else if (m_mode == 1) begin
          if (dw(m_tab[0]) == 0) begin
            to_idle = 1'b1;
            m_done  = 1'b1;
          end else begin
            model_load(0);
          end
        end else if (m_left > 0) begin
          m_left--;
        end else begin
          nxt = m_idx + 1;
          if (nxt < 8 && dw(m_tab[nxt % 8]) != 0) model_load(nxt);
          else if (loop && dw(m_tab[0]) != 0) model_load(0);
          else begin
            to_idle = 1'b1;
            m_done  = 1'b1;
          end
        end
      end
    end
    if (to_idle) begin
      m_mode = 0; m_stop = 1'b0; m_idx = 0;
      m_en = man_enable; m_sc = man_scale;
    end
    if (wr_en) m_tab[wr_addr] = wr_data;
    m_cnt = (m_cnt + 1) % 64;
  endtask

  task automatic cycle();
    @(posedge sysclk);
    model_step();
    @(negedge sysclk);
    check("enable", 32'(Enable_SW), 32'(m_en));
    check("scale", 32'(Scale), 32'(m_sc));
    check("tick", 32'(frame_tick), 32'(m_cnt == 63));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("step_idx", 32'(step_idx), 32'(m_idx));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [2:0] a, input int dwell, input logic [5:0] sc, input logic [3:0] en);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {16'(dwell), sc, en};
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; man_enable = 4'b0101; man_scale = 6'd20;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 26'd0;
    run(2);
    rst_n = 1'b1;
    run(130);

    // Two-step table terminated by a zero-dwell entry, single pass
    wr(3'd0, 3, 6'd40, 4'd1);
    wr(3'd1, 2, 6'd10, 4'd8);
    wr(3'd2, 0, 6'd0, 4'd0);
    loop = 1'b0;
    pulse_start();
    run(64 * 8);

    // Same table looping, then stopped
    loop = 1'b1;
    pulse_start();
    run(64 * 14);
    stop = 1'b1;
    run(70);
    stop = 1'b0;

    // Stop pulse mid-frame during step 1
    loop = 1'b0;
    pulse_start();
    guard = 0;
    while (m_idx != 1 && guard < 1000) begin
      cycle();
      guard++;
    end
    check("reach_step1", 32'(guard < 1000), 32'd1);
    run(20);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    run(150);

    // Entry 0 empty, then start and stop together
    wr(3'd0, 0, 6'd0, 4'd0);
    pulse_start();
    run(140);
    start = 1'b1; stop = 1'b1;
    run(140);
    start = 1'b0; stop = 1'b0;

    // Full table of one-frame entries, then reset mid-run
    for (int i = 0; i < 8; i++) wr(3'(i), 1, 6'($urandom), 4'($urandom));
    pulse_start();
    run(64 * 11);
    pulse_start();
    run(64 * 4 + 10);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(10);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 8; i++)
        wr(3'(i), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3), 6'($urandom), 4'($urandom));
      loop = 1'($urandom);
      pulse_start();
      for (int c = 0; c < int'($urandom_range(100, 600)); c++) begin
        start = ($urandom_range(0, 99) < 3);
        stop  = ($urandom_range(0, 499) == 0);
        wr_en = ($urandom_range(0, 99) < 2);
        wr_addr = 3'($urandom);
        wr_data = {16'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3)), 6'($urandom), 4'($urandom)};
        if ($urandom_range(0, 199) == 0) loop = ~loop;
        if ($urandom_range(0, 49) == 0) begin
          man_enable = 4'($urandom);
          man_scale  = 6'($urandom);
        end
        cycle();
      end
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
